// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared constants and the receive-FIFO entry layout for the UART.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 16;

    // Entry layout is {serr, perr, data}; flags sit directly above the data byte.
    localparam int PERR_BIT = WIDTH_DEFAULT;
    localparam int SERR_BIT = WIDTH_DEFAULT + 1;

    typedef struct packed {
        logic                     serr;
        logic                     perr;
        logic [WIDTH_DEFAULT-1:0] data;
    } rx_entry_t;

    function automatic int perr_bit(input int width);
        return width;
    endfunction

    function automatic int serr_bit(input int width);
        return width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_rise.sv
// ============================================================================
//  Module   : sync_rise
//  Brief    : Two-flop synchronizer followed by a registered rising-edge pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    // Resetting the chain to RST_VAL means a level already high at reset
    // release never looks like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Show-ahead receive FIFO capturing UART frames with sticky overrun.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int DROP_ERR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         Rx_Data,
    input  logic                     valid_rx,
    input  logic                     parity_error,
    input  logic                     stop_error,
    output logic [WIDTH-1:0]         dout_data,
    output logic                     dout_perr,
    output logic                     dout_serr,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    input  logic                     ovr_clr
);

    localparam int C_AW   = $clog2(DEPTH);
    localparam int C_CW   = C_AW + 1;
    localparam int C_PERR = perr_bit(WIDTH);
    localparam int C_SERR = serr_bit(WIDTH);

    logic [WIDTH+1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_CW-1:0]  r_count;
    logic             r_overrun;

    logic             w_wr_pulse;
    logic             w_err;
    logic             w_wr_req;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_ovr_set;
    logic [WIDTH+1:0] w_head;

    sync_rise #(
        .RST_VAL (1'b1)
    ) u_sync_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (valid_rx),
        .rise (w_wr_pulse)
    );

    assign w_err     = parity_error | stop_error;
    assign w_wr_req  = w_wr_pulse & ~((DROP_ERR != 0) & w_err);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_CW'(DEPTH));
    assign w_pop     = ~w_empty & dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr      = w_wr_req & (~w_full | w_pop);
    assign w_ovr_set = w_wr_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {stop_error, parity_error, Rx_Data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Memory is not reset, so the head is masked to zero while empty.
    assign w_head     = r_mem[r_rd_ptr];
    assign dout_data  = w_empty ? '0   : w_head[WIDTH-1:0];
    assign dout_perr  = w_empty ? 1'b0 : w_head[C_PERR];
    assign dout_serr  = w_empty ? 1'b0 : w_head[C_SERR];
    assign dout_valid = ~w_empty;
    assign count      = r_count;
    assign full       = w_full;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each completed frame (data byte plus parity and stop error flags) when `valid_rx` rises, and stores it in a circular FIFO. The stored entries are presented to the host/consumer over a valid/ready interface. Overflow is reported with a sticky flag, so bursts of received bytes are not silently lost by a slow consumer.

## Interface
Parameters:
- `WIDTH`, 8: data byte width; must match the receiver `WIDTH`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DROP_ERR`, 0: when 1, frames with `parity_error` or `stop_error` set are discarded and not stored.

Ports:
- `clk`  in  1: system clock (50 MHz). Single clock for the whole block.
- `rst`  in  1: asynchronous, active-high reset.
- `Rx_Data`  in  WIDTH: received byte from the receiver. Stable while `valid_rx` is high.
- `valid_rx`  in  1: frame-complete level from the receiver. Produced in the slow tick domain; held ≥ 4 `clk` cycles.
- `parity_error`  in  1: frame parity flag, qualified with `valid_rx`.
- `stop_error`  in  1: frame stop-bit flag, qualified with `valid_rx`.
- `dout_data`  out  WIDTH: head-of-FIFO byte (show-ahead).
- `dout_perr`  out  1: parity flag of the head entry.
- `dout_serr`  out  1: stop flag of the head entry.
- `dout_valid`  out  1: FIFO not empty.
- `dout_ready`  in  1: consumer accepts the head entry.
- `count`  out  $clog2(DEPTH)+1: number of stored entries.
- `full`  out  1: `count == DEPTH`.
- `overrun`  out  1: sticky; a frame arrived while full and was dropped.
- `ovr_clr`  in  1: clears `overrun`.

## Operation
- Capture path: `valid_rx` passes through a 2-flop synchronizer, then a rising-edge detector (third flop). A detected edge produces a one-cycle `wr_req`.
- `wr_req` samples {`stop_error`, `parity_error`, `Rx_Data`} in the same cycle. Entry width is WIDTH+2.
- Gating: if `DROP_ERR == 1` and either error flag is set, `wr_req` is suppressed. A suppressed frame does not count as an overrun.
- `pop = dout_valid & dout_ready`.
- Write accepted when `!full | pop`. A write while full, in a cycle with no pop, drops the frame and sets `overrun`.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- `count`: +1 on write only, −1 on pop only, unchanged when both occur or neither occurs.
- Empty with simultaneous write and pop: impossible, because `dout_valid` is 0 when empty. The write proceeds normally.
- Full with simultaneous write and pop: both take effect, `count` stays at DEPTH, no overrun.
- `overrun` priority: set has priority over `ovr_clr` in the same cycle.
- `dout_*` are read combinationally from `mem[rd_ptr]`. They are don't-care while `dout_valid == 0`.

## Timing
- Reset values:
  - `count = 0`, `full = 0`, `dout_valid = 0`, `overrun = 0`.
  - `dout_data`, `dout_perr`, `dout_serr` = 0: memory contents are not reset; outputs are forced to 0 while empty.
  - Both pointers = 0.
  - All three synchronizer/edge flops reset to 1. A `valid_rx` held high across reset release therefore produces no write.
- Latency: `valid_rx` rise sampled at clk edge N → `wr_req` asserted in cycle N+2. The entry is written at edge N+3, so `dout_valid` is high from N+3 when the FIFO was empty.
- Pop: the head entry is removed at the clk edge where `pop` is high. The next entry is visible in the following cycle.
- Back-to-back pops: one per cycle, sustained.
- Back-to-back writes: at most one per `valid_rx` rising edge. A `valid_rx` that stays high never generates a second write.
- Reset mid-operation: reset takes effect immediately (asynchronous). All stored entries and any pending `wr_req` are discarded.

## Structure
- `uart_pkg`:
  - default `DEPTH`
  - entry field offsets (`PERR_BIT = WIDTH`, `SERR_BIT = WIDTH+1`)
  - a `rx_entry_t` packed struct {serr, perr, data}
- Sub-module `sync_rise`: parameterizable 2-flop synchronizer plus rising-edge pulse, with the reset value as a parameter (1 here). It is reused for the `transmit` input on the TX side.
- FIFO storage: inferred register array, no vendor RAM.

## Test plan
- Basic path: single frame 0xA5, no errors → `dout_valid` rises exactly 3 cycles after `valid_rx`, `dout_data = 0xA5`, `count = 1`. With `dout_ready = 1`, the next cycle shows `count = 0`, `dout_valid = 0`.
- Fill and overrun: 16 frames 0x00..0x0F, `dout_ready = 0` → `full = 1`, `count = 16`. A 17th frame 0xFF sets `overrun`. Draining then yields 0x00..0x0F in order; 0xFF never appears.
- Full with simultaneous write and pop: FIFO full, hold `dout_ready = 1` in the write cycle → `count` stays 16, no overrun, last entry read equals the new byte.
- Error handling:
  - `DROP_ERR = 0`, frame 0x3C with `parity_error = 1` → stored with `dout_perr = 1`.
  - `DROP_ERR = 1`, same frame → not stored, `count` stays 0, `overrun` stays 0.
- Held level and reset:
  - `valid_rx` held high for 100 cycles → exactly one write.
  - Assert `rst` with 5 entries stored → `count = 0`, `dout_valid = 0`, `overrun = 0` immediately.
  - `valid_rx` high at reset release → no write.
- `overrun` clear priority: `ovr_clr` and an overrunning write in the same cycle → `overrun = 1`. `ovr_clr` alone next cycle → `overrun = 0`.
